// File: rtl/vfpu_result_buffer.sv
// Result FIFO between the VFPU and an HWPE-stream sink, with job sequencing and skid-based stall.
// Optional per-entry exception flags are enabled with `define VFPU_RESULT_FLAGS_EN.
module vfpu_result_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int SKID        = 2,
    parameter int FLAGS_WIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [15:0]             len_i,
    input  logic [DATA_WIDTH-1:0]   result_i,
    input  logic                    result_valid_i,
    input  logic [FLAGS_WIDTH-1:0]  flags_i,
    output logic                    stall_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [FLAGS_WIDTH-1:0]  out_flags_o,
    output logic [FLAGS_WIDTH-1:0]  flags_acc_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     pushed_q, pushed_d;
    logic [15:0]     popped_q, popped_d;
    logic            error_q, error_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic job_init;

    assign full = (count_q == FULL_CNT);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        pushed_d = pushed_q;
        popped_d = popped_q;
        error_d  = error_q;
        pop      = 1'b0;
        push     = 1'b0;
        job_init = 1'b0;

        if (clear_i) begin
            state_d  = IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pushed_d = '0;
            popped_d = '0;
            error_d  = 1'b0;
        end else begin
            pop  = (count_q != '0) && out_ready_i;
            // A full FIFO still accepts a push when the head leaves in the same cycle.
            push = result_valid_i && (state_q == RUN) && (!full || pop);

            if (result_valid_i && ((state_q != RUN) || (full && !pop)))
                error_d = 1'b1;

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pushed_d = pushed_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                popped_d = popped_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != 16'd0) begin
                            state_d  = RUN;
                            job_init = 1'b1;
                            len_d    = len_i;
                            pushed_d = '0;
                            popped_d = '0;
                            error_d  = 1'b0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    if (push && (pushed_d == len_q))
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (pop && (popped_d == len_q))
                        state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            pushed_q <= '0;
            popped_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            pushed_q <= pushed_d;
            popped_q <= popped_d;
            error_q  <= error_d;
        end
    end

    // Storage needs no reset: out_valid_o masks any entry not yet written.
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= result_i;
    end

`ifdef VFPU_RESULT_FLAGS_EN
    logic [FLAGS_WIDTH-1:0] fmem_q [DEPTH];
    logic [FLAGS_WIDTH-1:0] flags_acc_q, flags_acc_d;

    always_comb begin
        flags_acc_d = flags_acc_q;
        if (clear_i || job_init)
            flags_acc_d = '0;
        else if (push)
            flags_acc_d = flags_acc_q | flags_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            flags_acc_q <= '0;
        else
            flags_acc_q <= flags_acc_d;
    end

    always_ff @(posedge clk_i) begin
        if (push)
            fmem_q[wr_ptr_q] <= flags_i;
    end

    assign out_flags_o = out_valid_o ? fmem_q[rd_ptr_q] : '0;
    assign flags_acc_o = flags_acc_q;
`else
    logic unused_flags;
    assign unused_flags = ^{flags_i, job_init};
    assign out_flags_o  = '0;
    assign flags_acc_o  = '0;
`endif

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_strb_o  = '1;
    assign stall_o     = (count_q >= STALL_CNT) || (state_q != RUN);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign error_o     = error_q;

endmodule

// File: tb/tb_vfpu_result_buffer.sv
// Directed self-checking bench for vfpu_result_buffer at DEPTH=4, SKID=2.
module tb_vfpu_result_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] len_i = '0;
    logic [31:0] result_i = '0;
    logic        result_valid_i = 1'b0;
    logic [4:0]  flags_i = '0;
    logic        stall_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_strb_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [4:0]  out_flags_o;
    logic [4:0]  flags_acc_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    int n_tot = 0;
    int n_bad = 0;

`ifdef VFPU_RESULT_FLAGS_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    vfpu_result_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .SKID       (2),
        .FLAGS_WIDTH(5)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .len_i         (len_i),
        .result_i      (result_i),
        .result_valid_i(result_valid_i),
        .flags_i       (flags_i),
        .stall_o       (stall_o),
        .out_data_o    (out_data_o),
        .out_strb_o    (out_strb_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_flags_o   (out_flags_o),
        .flags_acc_o   (flags_acc_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input logic [15:0] n);
        start_i = 1'b1;
        len_i   = n;
        step();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] f);
        result_valid_i = 1'b1;
        result_i       = d;
        flags_i        = f;
        step();
        result_valid_i = 1'b0;
        flags_i        = '0;
    endtask

    logic [31:0] exp_words [3];

    initial begin
        exp_words[0] = 32'h3F80_0000;
        exp_words[1] = 32'h4000_0000;
        exp_words[2] = 32'h4040_0000;

        step();
        step();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", error_o, 0);
        chk("rst_stall", stall_o, 1);
        chk("rst_facc", flags_acc_o, 0);
        chk("rst_oflags", out_flags_o, 0);
        rst_i = 1'b0;
        step();
        chk("strb", out_strb_o, 4'hF);

        // Three-word job streamed straight through with the sink always ready.
        start_job(16'd3);
        chk("j1_busy", busy_o, 1);
        chk("j1_stall", stall_o, 0);
        chk("j1_novalid", out_valid_o, 0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(exp_words[i], 5'b0);
            chk($sformatf("j1_valid%0d", i), out_valid_o, 1);
            chk($sformatf("j1_data%0d", i), out_data_o, exp_words[i]);
        end
        step();
        chk("j1_empty", out_valid_o, 0);
        chk("j1_done", done_o, 1);
        step();
        chk("j1_done_off", done_o, 0);
        chk("j1_idle", busy_o, 0);

        // Fill with sink stalled, then overflow.
        out_ready_i = 1'b0;
        start_job(16'd8);
        push(32'hA0, 5'b0);
        chk("ov_stall1", stall_o, 0);
        push(32'hA1, 5'b0);
        chk("ov_stall2", stall_o, 1);
        push(32'hA2, 5'b0);
        push(32'hA3, 5'b0);
        chk("ov_err_pre", error_o, 0);
        push(32'hA4, 5'b0);
        chk("ov_err", error_o, 1);
        chk("ov_hold", out_data_o, 32'hA0);
        step();
        chk("ov_stable", out_data_o, 32'hA0);
        out_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("ov_drain%0d", i), out_data_o, 32'hA0 + i);
        end
        step();
        chk("ov_cnt4", out_valid_o, 0);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("ov_clr_err", error_o, 0);
        chk("ov_clr_busy", busy_o, 0);

        // Full FIFO with simultaneous push and pop.
        out_ready_i = 1'b0;
        start_job(16'd5);
        for (int i = 0; i < 4; i++) push(32'hB0 + i, 5'b0);
        out_ready_i = 1'b1;
        push(32'hB4, 5'b0);
        chk("pp_err", error_o, 0);
        chk("pp_head", out_data_o, 32'hB1);
        for (int i = 2; i < 5; i++) begin
            step();
            chk($sformatf("pp_word%0d", i), out_data_o, 32'hB0 + i);
        end
        chk("pp_notdone", done_o, 0);
        step();
        chk("pp_empty", out_valid_o, 0);
        chk("pp_done", done_o, 1);
        step();
        chk("pp_idle", busy_o, 0);

        // Zero-length job.
        start_job(16'd0);
        chk("z_done", done_o, 1);
        chk("z_valid", out_valid_o, 0);
        step();
        chk("z_done_off", done_o, 0);
        chk("z_idle", busy_o, 0);

        // Stray push outside RUN.
        push(32'hDEAD, 5'b0);
        chk("stray_err", error_o, 1);
        chk("stray_valid", out_valid_o, 0);

        // Flags: accumulate and follow the head entry.
        out_ready_i = 1'b0;
        start_job(16'd2);
        chk("fl_err_clr", error_o, 0);
        push(32'hC0, 5'b00001);
        chk("fl_acc1", flags_acc_o, FEN ? 5'b00001 : 5'b0);
        chk("fl_head1", out_flags_o, FEN ? 5'b00001 : 5'b0);
        push(32'hC1, 5'b10000);
        chk("fl_acc2", flags_acc_o, FEN ? 5'b10001 : 5'b0);
        chk("fl_head2", out_flags_o, FEN ? 5'b00001 : 5'b0);
        out_ready_i = 1'b1;
        step();
        chk("fl_head3", out_flags_o, FEN ? 5'b10000 : 5'b0);
        chk("fl_data3", out_data_o, 32'hC1);
        step();
        chk("fl_done", done_o, 1);
        step();

        // Clear mid-job with two entries queued.
        out_ready_i = 1'b0;
        start_job(16'd4);
        push(32'hD0, 5'b0);
        push(32'hD1, 5'b0);
        chk("cl_pre_valid", out_valid_o, 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("cl_valid", out_valid_o, 0);
        chk("cl_busy", busy_o, 0);
        chk("cl_err", error_o, 0);
        chk("cl_done", done_o, 0);
        step();
        chk("cl_done2", done_o, 0);

        // Fresh job after clear starts from an empty FIFO.
        start_job(16'd1);
        push(32'hE0, 5'b0);
        chk("post_data", out_data_o, 32'hE0);
        out_ready_i = 1'b1;
        step();
        chk("post_done", done_o, 1);
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
